// File: rtl/regread_port_arbiter.sv
// Round-robin arbiter that shares one register-file read port (8:1 mux) among
// NREQ requesters, with a bounded lock so multi-register bursts keep the port.
// The mux select is driven in the grant cycle and the mux output is registered,
// so read data returns one cycle after the grant.
module regread_port_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 3,
    parameter int unsigned DW      = 16,
    parameter int unsigned MAXLOCK = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] raddr,
    input  logic               hold,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      mux_sel,
    input  logic [DW-1:0]      mux_out,
    output logic [DW-1:0]      rdata,
    output logic [NREQ-1:0]    rvalid
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 4;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;

    logic            lock_hit;
    logic            gnt_vld;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   scan_idx;
    logic [CW-1:0]   cnt_next;

    // Grant selection: locked owner first, otherwise first request from ptr.
    always_comb begin
        lock_hit = 1'b0;
        gnt_vld  = 1'b0;
        gidx     = '0;
        scan_idx = '0;
        if (reset_n && !hold) begin
            lock_hit = owner_vld_q && req[owner_q] && (32'(lock_cnt_q) < MAXLOCK);
            if (lock_hit) begin
                gnt_vld = 1'b1;
                gidx    = owner_q;
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    scan_idx = IW'((32'(ptr_q) + k) % NREQ);
                    if (!gnt_vld && req[scan_idx]) begin
                        gnt_vld = 1'b1;
                        gidx    = scan_idx;
                    end
                end
            end
        end
    end

    // One-hot grant and shared mux select (zero latency).
    always_comb begin
        gnt     = '0;
        mux_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_vld && (gidx == IW'(i))) begin
                gnt[i]  = 1'b1;
                mux_sel = raddr[i*AW +: AW];
            end
        end
    end

    // Next state for lock tracking, pointer and read-data capture.
    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        lock_cnt_d  = lock_cnt_q;
        rdata_d     = rdata_q;
        rvalid_d    = gnt;
        // A grant that did not come from the live lock starts a fresh count.
        cnt_next    = (lock_hit ? lock_cnt_q : CW'(0)) + CW'(1);
        if (gnt_vld) begin
            rdata_d = mux_out;
            if (lock[gidx] && (32'(cnt_next) < MAXLOCK)) begin
                owner_d     = gidx;
                owner_vld_d = 1'b1;
                lock_cnt_d  = cnt_next;
            end else begin
                owner_vld_d = 1'b0;
                lock_cnt_d  = '0;
                ptr_d       = (32'(gidx) == NREQ - 1) ? '0 : gidx + IW'(1);
            end
        end else if (!hold) begin
            // Nobody granted outside a stall: any lock has been abandoned.
            owner_vld_d = 1'b0;
            lock_cnt_d  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            lock_cnt_q  <= '0;
            rdata_q     <= '0;
            rvalid_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            lock_cnt_q  <= lock_cnt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule
